regfile_verify_harness: RTL and testbench
=========================================

// Module: regfile_verify_harness
// PURPOSE
//  Synthesisable run-then-check harness for processor bring-up. Counts a programmed number of clocks and emits a trace record
//  for every non-zero register write. It then hijacks the regfile read port A and scans all registers, comparing each against an
//  expected-value ROM. Reports a per-mismatch record, an error count and pass/done flags. Sits beside processor/regfile in Wrapper.
// PARAMETERS
//  DATA_WIDTH   32  register/expected data width
//  NUM_REGS     32  registers scanned (indices 0..NUM_REGS-1)
//  ADDR_WIDTH   5   register index width; must satisfy 2**ADDR_WIDTH >= NUM_REGS
//  CYCLE_WIDTH  16  width of run-cycle counter and num_cycles
// PORTS
//  clock        in   1            system clock, all state on rising edge
//  reset        in   1            asynchronous, active-high; clears all state
//  start        in   1            begin run (sampled in IDLE or DONE only)
//  num_cycles   in   CYCLE_WIDTH  run length in clocks, sampled with start
//  rwe          in   1            processor regfile write enable (observed)
//  rd           in   ADDR_WIDTH   processor write register (observed)
//  rData        in   DATA_WIDTH   processor write data (observed)
//  test_mode    out  1            high = regfile read port A driven by test_reg
//  test_reg     out  ADDR_WIDTH   register index to read during scan
//  reg_data     in   DATA_WIDTH   regfile read-port-A data (combinational from test_reg)
//  exp_addr     out  ADDR_WIDTH   expected-ROM address (== test_reg)
//  exp_data     in   DATA_WIDTH   expected-ROM data, 1-cycle synchronous latency
//  trace_valid  out  1            one-cycle pulse: trace record valid
//  trace_cycle  out  CYCLE_WIDTH  run-cycle index of the logged write
//  trace_reg    out  ADDR_WIDTH   logged write register
//  trace_data   out  DATA_WIDTH   logged write data
//  fail_valid   out  1            one-cycle pulse: mismatch record valid
//  fail_reg     out  ADDR_WIDTH   mismatching register
//  fail_exp     out  DATA_WIDTH   expected value
//  fail_act     out  DATA_WIDTH   actual value
//  error_count  out  ADDR_WIDTH+1 mismatches this check, saturating
//  busy         out  1            high in RUN/SCAN/DRAIN
//  done         out  1            high in DONE
//  pass         out  1            done && error_count==0
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0, counters 0. Reset mid-run aborts at once; no partial done/pass.
//  - States: IDLE -> RUN -> SCAN -> DRAIN -> DONE. start in DONE re-enters RUN. start in RUN/SCAN/DRAIN is ignored.
//  - IDLE/DONE + start: latch num_cycles, clear cyc_cnt and error_count, done=0.
//    Next state is RUN, or SCAN directly if num_cycles==0.
//  - RUN: cyc_cnt increments each clock from 0. If rwe && rd!=0 in cycle k, trace_valid pulses the next cycle
//    with trace_cycle=k, trace_reg=rd, trace_data=rData.
//    On the clock where cyc_cnt==num_cycles-1: log that cycle's write (if any), then go to SCAN with scan_idx=0.
//  - SCAN: test_mode=1, test_reg=exp_addr=scan_idx. Each cycle: register (scan_idx, reg_data), scan_idx++.
//    After issuing NUM_REGS-1, go to DRAIN. rwe activity is not traced.
//  - Compare (SCAN cycles after the first, plus DRAIN): registered actual vs exp_data, which arrives aligned via ROM latency.
//    Bitwise !=: fail_valid pulses with fail_reg/fail_exp/fail_act; error_count++ saturating at all-ones.
//  - DRAIN: test_mode stays 1, final compare, then DONE. test_mode=0 outside SCAN/DRAIN.
//  - DONE: done=1 and pass held until start or reset. Trace/fail records hold their last values; valids are 0.
//  - Total latency from start to done: num_cycles + NUM_REGS + 1 clocks.
// TESTING
//  1. num_cycles=5, rwe=1 rd=3 rData=7 in run cycle 2 -> trace_valid once, trace_cycle=2 reg=3 data=7.
//     rd=0 writes are never traced.
//  2. Regfile equals ROM for all 32 regs -> done after 5+33 clocks, error_count=0, pass=1, no fail_valid.
//  3. Reg 31 actual=-1, expected=0 -> single fail_valid in DRAIN, fail_reg=31 exp=0 act=0xFFFFFFFF, error_count=1, pass=0.
//  4. num_cycles=0 -> RUN skipped, test_mode rises the clock after start, done after 33 clocks.
//  5. Reset asserted mid-SCAN at scan_idx=10 -> all outputs 0 immediately. Then start -> full clean run, error_count restarts at 0.
//  6. start held during RUN and pulsed again in DONE -> first ignored, second restarts with done=0, error_count cleared.

Source files
------------

// File: rtl/regfile_verify_harness.sv
// regfile_verify_harness
//   Run-then-check harness for processor bring-up. After start it lets the
//   processor run for num_cycles clocks and emits a trace record for every
//   write to a non-zero register. It then takes over regfile read port A,
//   walks every register and compares it against an expected-value ROM.
//   Each mismatch produces a fail record. A saturating error count and
//   done/pass flags summarise the check.
//
// Ports
//   clock, reset            system clock; asynchronous active-high reset
//   start, num_cycles       launch a run of num_cycles clocks (IDLE/DONE only)
//   rwe, rd, rData          observed processor regfile write port
//   test_mode, test_reg     read-port-A override and index during the scan
//   reg_data                read-port-A data, combinational from test_reg
//   exp_addr, exp_data      expected ROM address / data (1-cycle latency)
//   trace_*                 write trace record, trace_valid is a 1-clock pulse
//   fail_*                  mismatch record, fail_valid is a 1-clock pulse
//   error_count             mismatches in this check, saturating
//   busy, done, pass        status flags
//   dbg_state               current FSM state for checkers
//
// Handshake: start is a level, sampled on a rising clock edge only while the
// FSM is in IDLE or DONE; it is ignored in every other state and there is no
// ready. trace_valid/fail_valid are single-clock pulses with no back-pressure:
// the consumer must capture the record in the cycle the valid is high.
module regfile_verify_harness #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int CYCLE_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [CYCLE_WIDTH-1:0] num_cycles,
    input  logic                   rwe,
    input  logic [ADDR_WIDTH-1:0]  rd,
    input  logic [DATA_WIDTH-1:0]  rData,
    output logic                   test_mode,
    output logic [ADDR_WIDTH-1:0]  test_reg,
    input  logic [DATA_WIDTH-1:0]  reg_data,
    output logic [ADDR_WIDTH-1:0]  exp_addr,
    input  logic [DATA_WIDTH-1:0]  exp_data,
    output logic                   trace_valid,
    output logic [CYCLE_WIDTH-1:0] trace_cycle,
    output logic [ADDR_WIDTH-1:0]  trace_reg,
    output logic [DATA_WIDTH-1:0]  trace_data,
    output logic                   fail_valid,
    output logic [ADDR_WIDTH-1:0]  fail_reg,
    output logic [DATA_WIDTH-1:0]  fail_exp,
    output logic [DATA_WIDTH-1:0]  fail_act,
    output logic [ADDR_WIDTH:0]    error_count,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [2:0]             dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_SCAN  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [CYCLE_WIDTH-1:0] r_num_cycles;
    logic [CYCLE_WIDTH-1:0] r_cyc_cnt;
    logic [ADDR_WIDTH-1:0]  r_scan_idx;
    // Compare pipeline: the register read in one scan cycle is held here
    // while the ROM produces the matching expected word one clock later.
    logic                   r_cmp_vld;
    logic [ADDR_WIDTH-1:0]  r_cmp_reg;
    logic [DATA_WIDTH-1:0]  r_act;
    logic                   r_trace_valid;
    logic [CYCLE_WIDTH-1:0] r_trace_cycle;
    logic [ADDR_WIDTH-1:0]  r_trace_reg;
    logic [DATA_WIDTH-1:0]  r_trace_data;
    logic                   r_fail_valid;
    logic [ADDR_WIDTH-1:0]  r_fail_reg;
    logic [DATA_WIDTH-1:0]  r_fail_exp;
    logic [DATA_WIDTH-1:0]  r_fail_act;
    logic [ADDR_WIDTH:0]    r_err;

    logic w_start_ok;
    logic w_run_last;
    logic w_scan_last;
    logic w_mismatch;

    assign w_start_ok  = start && (r_state == S_IDLE || r_state == S_DONE);
    // Only evaluated in RUN, which is never entered with num_cycles == 0.
    assign w_run_last  = (r_cyc_cnt == (r_num_cycles - CYCLE_WIDTH'(1)));
    assign w_scan_last = (r_scan_idx == ADDR_WIDTH'(NUM_REGS - 1));
    assign w_mismatch  = r_cmp_vld && (r_act != exp_data);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next = (num_cycles == '0) ? S_SCAN : S_RUN;
                end
            end
            S_RUN:   if (w_run_last)  w_next = S_SCAN;
            S_SCAN:  if (w_scan_last) w_next = S_DRAIN;
            S_DRAIN: w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_num_cycles  <= '0;
            r_cyc_cnt     <= '0;
            r_scan_idx    <= '0;
            r_cmp_vld     <= 1'b0;
            r_cmp_reg     <= '0;
            r_act         <= '0;
            r_trace_valid <= 1'b0;
            r_trace_cycle <= '0;
            r_trace_reg   <= '0;
            r_trace_data  <= '0;
            r_fail_valid  <= 1'b0;
            r_fail_reg    <= '0;
            r_fail_exp    <= '0;
            r_fail_act    <= '0;
            r_err         <= '0;
        end else begin
            r_trace_valid <= 1'b0;
            r_fail_valid  <= 1'b0;
            r_cmp_vld     <= (r_state == S_SCAN);

            if (w_start_ok) begin
                r_num_cycles <= num_cycles;
                r_cyc_cnt    <= '0;
                r_scan_idx   <= '0;
                r_err        <= '0;
            end

            if (r_state == S_RUN) begin
                r_cyc_cnt <= r_cyc_cnt + CYCLE_WIDTH'(1);
                if (rwe && rd != '0) begin
                    r_trace_valid <= 1'b1;
                    r_trace_cycle <= r_cyc_cnt;
                    r_trace_reg   <= rd;
                    r_trace_data  <= rData;
                end
                if (w_run_last) begin
                    r_scan_idx <= '0;
                end
            end

            if (r_state == S_SCAN) begin
                r_act     <= reg_data;
                r_cmp_reg <= r_scan_idx;
                if (!w_scan_last) begin
                    r_scan_idx <= r_scan_idx + ADDR_WIDTH'(1);
                end
            end

            // The last compare happens during DRAIN; its record and the
            // final error count become visible together with done.
            if (w_mismatch) begin
                r_fail_valid <= 1'b1;
                r_fail_reg   <= r_cmp_reg;
                r_fail_exp   <= exp_data;
                r_fail_act   <= r_act;
                if (r_err != '1) begin
                    r_err <= r_err + (ADDR_WIDTH + 1)'(1);
                end
            end
        end
    end

    assign test_mode   = (r_state == S_SCAN) || (r_state == S_DRAIN);
    assign test_reg    = test_mode ? r_scan_idx : '0;
    assign exp_addr    = test_reg;
    assign trace_valid = r_trace_valid;
    assign trace_cycle = r_trace_cycle;
    assign trace_reg   = r_trace_reg;
    assign trace_data  = r_trace_data;
    assign fail_valid  = r_fail_valid;
    assign fail_reg    = r_fail_reg;
    assign fail_exp    = r_fail_exp;
    assign fail_act    = r_fail_act;
    assign error_count = r_err;
    assign busy        = (r_state == S_RUN) || test_mode;
    assign done        = (r_state == S_DONE);
    assign pass        = done && (r_err == '0);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_regfile_verify_harness.sv
module tb_regfile_verify_harness;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int CW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] num_cycles = '0;
    logic          rwe = 1'b0;
    logic [AW-1:0] rd = '0;
    logic [DW-1:0] rData = '0;
    logic          test_mode;
    logic [AW-1:0] test_reg;
    logic [DW-1:0] reg_data;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data = '0;
    logic          trace_valid;
    logic [CW-1:0] trace_cycle;
    logic [AW-1:0] trace_reg;
    logic [DW-1:0] trace_data;
    logic          fail_valid;
    logic [AW-1:0] fail_reg;
    logic [DW-1:0] fail_exp;
    logic [DW-1:0] fail_act;
    logic [AW:0]   error_count;
    logic          busy;
    logic          done;
    logic          pass;
    logic [2:0]    dbg_state;

    // clock / reset block
    always #5 clock = ~clock;

    // regfile and expected ROM models
    logic [DW-1:0] regs [NR];
    logic [DW-1:0] rom  [NR];
    assign reg_data = regs[test_reg];
    always @(posedge clock) exp_data <= rom[exp_addr];

    regfile_verify_harness #(
        .DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .CYCLE_WIDTH(CW)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
        .rwe(rwe), .rd(rd), .rData(rData),
        .test_mode(test_mode), .test_reg(test_reg), .reg_data(reg_data),
        .exp_addr(exp_addr), .exp_data(exp_data),
        .trace_valid(trace_valid), .trace_cycle(trace_cycle),
        .trace_reg(trace_reg), .trace_data(trace_data),
        .fail_valid(fail_valid), .fail_reg(fail_reg),
        .fail_exp(fail_exp), .fail_act(fail_act),
        .error_count(error_count), .busy(busy), .done(done), .pass(pass),
        .dbg_state(dbg_state)
    );

    int total = 0;
    int bad   = 0;

    // results of the most recent run
    int          lat;
    int          n_trace;
    int          n_fail;
    int          trace_k;
    int          fail_k;
    logic        tm_first;
    logic        busy_first;
    logic        done_first;
    logic [AW:0] err_first;

    task automatic fill_match();
        for (int i = 0; i < NR; i++) begin
            regs[i] = 32'h0101_0101 * i + 32'h00A0_0000 * (i % 3);
            rom[i]  = regs[i];
        end
    endtask

    // Launch a run and step it cycle by cycle. Cycle k=0 is the clock right
    // after the start edge. wr_cyc selects the cycle carrying the traced
    // write; every other cycle writes rd=0 during RUN and rd=9 during SCAN,
    // neither of which may be traced. start stays high for cycles k<hold_k.
    // abort_k>=0 returns at that cycle without waiting for done.
    task automatic run(input int n, input int wr_cyc, input int wr_rd,
                       input logic [DW-1:0] wr_data, input int hold_k,
                       input int abort_k);
        int k;
        @(negedge clock);
        start = 1'b1;
        num_cycles = CW'(n);
        rwe = 1'b0;
        @(negedge clock);
        n_trace = 0; n_fail = 0; trace_k = -1; fail_k = -1; lat = -1;
        tm_first = test_mode; busy_first = busy;
        done_first = done; err_first = error_count;
        k = 0;
        while (k < 300) begin
            if (k == abort_k) return;
            start = (k < hold_k);
            if (k == wr_cyc) begin
                rwe = 1'b1; rd = AW'(wr_rd); rData = wr_data;
            end else begin
                rwe = 1'b1; rd = (k < n) ? AW'(0) : AW'(9); rData = DW'(k + 100);
            end
            @(negedge clock);
            k++;
            if (trace_valid) begin n_trace++; trace_k = k; end
            if (fail_valid)  begin n_fail++;  fail_k = k;  end
            if (done) begin
                lat = k;
                break;
            end
        end
        rwe = 1'b0; rd = '0; rData = '0; start = 1'b0;
        total++;
        if (lat < 0) begin
            bad++;
            $display("FAIL run_timeout: done not seen within %0d cycles", k);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        total++;
        if ({test_mode, busy, done, pass, trace_valid, fail_valid} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000000",
                     {test_mode, busy, done, pass, trace_valid, fail_valid});
        end
        total++;
        if ({error_count, test_reg, dbg_state} !== '0) begin
            bad++;
            $display("FAIL reset_counts: err=%0d test_reg=%0d state=%0d want 0",
                     error_count, test_reg, dbg_state);
        end
        total++;
        if ({trace_cycle, trace_reg, trace_data, fail_reg, fail_exp, fail_act} !== '0) begin
            bad++;
            $display("FAIL reset_records: trace_cycle=%0d fail_reg=%0d want 0",
                     trace_cycle, fail_reg);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_trace_clean();
        fill_match();
        run(5, 2, 3, 32'd7, 0, -1);
        total++;
        if (tm_first !== 1'b0 || busy_first !== 1'b1) begin
            bad++;
            $display("FAIL run_first_cycle: test_mode=%b busy=%b want 0 1", tm_first, busy_first);
        end
        total++;
        if (n_trace !== 1 || trace_k !== 3) begin
            bad++;
            $display("FAIL trace_pulse: count=%0d at=%0d want 1 at 3", n_trace, trace_k);
        end
        total++;
        if (trace_cycle !== 16'd2 || trace_reg !== 5'd3 || trace_data !== 32'd7) begin
            bad++;
            $display("FAIL trace_record: cyc=%0d reg=%0d data=%h want 2 3 00000007",
                     trace_cycle, trace_reg, trace_data);
        end
        total++;
        if (lat !== 38) begin
            bad++;
            $display("FAIL clean_latency: got %0d want 38", lat);
        end
        total++;
        if (n_fail !== 0 || error_count !== 6'd0 || pass !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL clean_result: fails=%0d err=%0d pass=%b busy=%b want 0 0 1 0",
                     n_fail, error_count, pass, busy);
        end
        // records hold and valids stay low while parked in DONE
        repeat (3) @(negedge clock);
        total++;
        if (done !== 1'b1 || trace_valid !== 1'b0 || trace_reg !== 5'd3 || test_mode !== 1'b0) begin
            bad++;
            $display("FAIL done_hold: done=%b tv=%b treg=%0d tm=%b want 1 0 3 0",
                     done, trace_valid, trace_reg, test_mode);
        end
    endtask

    task automatic test_mismatch_last();
        fill_match();
        regs[31] = 32'hFFFF_FFFF;
        rom[31]  = 32'h0;
        run(5, -1, 0, '0, 0, -1);
        total++;
        if (n_fail !== 1 || fail_k !== 38) begin
            bad++;
            $display("FAIL last_fail_pulse: count=%0d at=%0d want 1 at 38", n_fail, fail_k);
        end
        total++;
        if (fail_reg !== 5'd31 || fail_exp !== 32'h0 || fail_act !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL last_fail_record: reg=%0d exp=%h act=%h want 31 00000000 ffffffff",
                     fail_reg, fail_exp, fail_act);
        end
        total++;
        if (error_count !== 6'd1 || pass !== 1'b0 || done !== 1'b1 || n_trace !== 0) begin
            bad++;
            $display("FAIL last_fail_status: err=%0d pass=%b done=%b traces=%0d want 1 0 1 0",
                     error_count, pass, done, n_trace);
        end
    endtask

    task automatic test_mismatch_multi();
        fill_match();
        regs[0]  = 32'h0000_0001;
        regs[17] = rom[17] ^ 32'h0000_8000;
        run(3, 0, 12, 32'hDEAD_BEEF, 0, -1);
        total++;
        if (n_fail !== 2 || error_count !== 6'd2) begin
            bad++;
            $display("FAIL multi_fail_count: pulses=%0d err=%0d want 2 2", n_fail, error_count);
        end
        total++;
        if (fail_reg !== 5'd17 || fail_act !== (rom[17] ^ 32'h0000_8000) || fail_exp !== rom[17]) begin
            bad++;
            $display("FAIL multi_fail_record: reg=%0d exp=%h act=%h want 17 %h %h",
                     fail_reg, fail_exp, fail_act, rom[17], rom[17] ^ 32'h0000_8000);
        end
        total++;
        if (trace_cycle !== 16'd0 || trace_reg !== 5'd12 || trace_data !== 32'hDEAD_BEEF || lat !== 36) begin
            bad++;
            $display("FAIL multi_trace_lat: cyc=%0d reg=%0d data=%h lat=%0d want 0 12 deadbeef 36",
                     trace_cycle, trace_reg, trace_data, lat);
        end
    endtask

    task automatic test_zero_cycles();
        fill_match();
        run(0, -1, 0, '0, 0, -1);
        total++;
        if (tm_first !== 1'b1) begin
            bad++;
            $display("FAIL zero_test_mode: got %b want 1", tm_first);
        end
        total++;
        if (lat !== 33 || n_trace !== 0 || pass !== 1'b1) begin
            bad++;
            $display("FAIL zero_result: lat=%0d traces=%0d pass=%b want 33 0 1", lat, n_trace, pass);
        end
    endtask

    task automatic test_reset_mid_scan();
        fill_match();
        regs[3] = 32'h1234_5678;
        run(2, -1, 0, '0, 0, 12);
        total++;
        if (test_reg !== 5'd10 || test_mode !== 1'b1 || error_count !== 6'd1) begin
            bad++;
            $display("FAIL pre_abort: test_reg=%0d tm=%b err=%0d want 10 1 1",
                     test_reg, test_mode, error_count);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({test_mode, busy, done, pass, test_reg, error_count, dbg_state} !== '0) begin
            bad++;
            $display("FAIL abort_outputs: tm=%b busy=%b done=%b reg=%0d err=%0d state=%0d want all 0",
                     test_mode, busy, done, test_reg, error_count, dbg_state);
        end
        rwe = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        fill_match();
        run(4, 1, 8, 32'h0000_00AB, 0, -1);
        total++;
        if (lat !== 37 || error_count !== 6'd0 || pass !== 1'b1 || n_fail !== 0) begin
            bad++;
            $display("FAIL after_abort: lat=%0d err=%0d pass=%b fails=%0d want 37 0 1 0",
                     lat, error_count, pass, n_fail);
        end
    endtask

    task automatic test_start_ignored();
        fill_match();
        regs[5] = ~rom[5];
        run(5, -1, 0, '0, 4, -1);
        total++;
        if (lat !== 38 || error_count !== 6'd1) begin
            bad++;
            $display("FAIL held_start: lat=%0d err=%0d want 38 1", lat, error_count);
        end
        fill_match();
        run(6, 5, 31, 32'h0BAD_F00D, 0, -1);
        total++;
        if (done_first !== 1'b0 || err_first !== 6'd0 || busy_first !== 1'b1) begin
            bad++;
            $display("FAIL restart_clear: done=%b err=%0d busy=%b want 0 0 1",
                     done_first, err_first, busy_first);
        end
        total++;
        if (lat !== 39 || pass !== 1'b1 || trace_cycle !== 16'd5 || trace_reg !== 5'd31) begin
            bad++;
            $display("FAIL restart_run: lat=%0d pass=%b tcyc=%0d treg=%0d want 39 1 5 31",
                     lat, pass, trace_cycle, trace_reg);
        end
    endtask

    initial begin
        fill_match();
        test_reset();
        test_trace_clean();
        test_mismatch_last();
        test_mismatch_multi();
        test_zero_cycles();
        test_reset_mid_scan();
        test_start_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
